transposed_buffer_reader9x4: RTL and testbench

Control and read-out block for the 9x4 transposed line buffer in the interpolation datapath.
- Accepts rows from upstream with a valid/ready handshake and drives the buffer's write enable.
- Counts 9 rows per block, then captures the buffer's 4 parallel column outputs into a shadow register.
- Serialises one column per handshake to the vertical filter, so the next block can fill while the current one drains.

---
 rtl/tbuf_pkg.sv | 27 ++
 rtl/tbuf_col_shadow.sv | 42 ++++
 rtl/transposed_buffer_reader9x4.sv | 82 ++++++++
 tb/tb_transposed_buffer_reader9x4.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/tbuf_pkg.sv
// Shared types and sizing for the 9x4 transposed line-buffer reader.
// The field-reversal helper serves the TBUF_READER_OLDEST_FIRST_EN build.
package tbuf_pkg;

  localparam int DATA_W    = 11;
  localparam int ROWS      = 9;
  localparam int COLS      = 4;
  localparam int COL_W     = ROWS * DATA_W;
  localparam int ROW_CNT_W = $clog2(ROWS);
  localparam int COL_IDX_W = $clog2(COLS);

  typedef enum logic {
    DRAIN_IDLE = 1'b0,
    DRAIN_FULL = 1'b1
  } drain_state_t;

  // Swap the order of the ROWS sample fields, so the oldest row lands in the MSBs.
  function automatic logic [COL_W-1:0] reverse_fields(input logic [COL_W-1:0] col);
    logic [COL_W-1:0] rev;
    rev = '0;
    for (int f = 0; f < ROWS; f++) begin
      rev[f*DATA_W +: DATA_W] = col[(ROWS-1-f)*DATA_W +: DATA_W];
    end
    return rev;
  endfunction

endpackage

// File: rtl/tbuf_col_shadow.sv
// Shadow bank: captures all 4 buffer columns in 1 cycle, then muxes one out by col_idx.
// The TBUF_READER_OLDEST_FIRST_EN build reverses the row fields at capture time.
module tbuf_col_shadow
  import tbuf_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 capture,
  input  logic [COL_W-1:0]     col_in_0,
  input  logic [COL_W-1:0]     col_in_1,
  input  logic [COL_W-1:0]     col_in_2,
  input  logic [COL_W-1:0]     col_in_3,
  input  logic [COL_IDX_W-1:0] col_idx,
  output logic [COL_W-1:0]     col_out
);

  logic [COL_W-1:0] shadow [COLS];

  function automatic logic [COL_W-1:0] orient(input logic [COL_W-1:0] col);
`ifdef TBUF_READER_OLDEST_FIRST_EN
    return reverse_fields(col);
`else
    return col;
`endif
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < COLS; c++) begin
        shadow[c] <= '0;
      end
    end else if (capture) begin
      shadow[0] <= orient(col_in_0);
      shadow[1] <= orient(col_in_1);
      shadow[2] <= orient(col_in_2);
      shadow[3] <= orient(col_in_3);
    end
  end

  assign col_out = shadow[col_idx];

endmodule

// File: rtl/transposed_buffer_reader9x4.sv
// Row-write control and column read-out for the 9x4 transposed buffer; COL_VALID 2 cycles after the 9th row.
// Rows stall only at the 9th row while the shadow is busy; TBUF_READER_OLDEST_FIRST_EN reverses row order.
module transposed_buffer_reader9x4
  import tbuf_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST_ASYNC_N,
  input  logic                 ROW_VALID,
  output logic                 ROW_READY,
  output logic                 BUF_WRITE_EN,
  input  logic [COL_W-1:0]     COL_IN_0,
  input  logic [COL_W-1:0]     COL_IN_1,
  input  logic [COL_W-1:0]     COL_IN_2,
  input  logic [COL_W-1:0]     COL_IN_3,
  output logic [COL_W-1:0]     COL_OUT,
  output logic [COL_IDX_W-1:0] COL_IDX,
  output logic                 COL_VALID,
  input  logic                 COL_READY,
  output logic                 BLOCK_DONE
);

  logic [ROW_CNT_W-1:0] row_cnt;
  logic                 capture_pend;
  drain_state_t         drain_state;
  logic [COL_IDX_W-1:0] col_idx;
  logic                 block_done;

  logic row_last;
  logic row_fire;
  logic col_fire;
  logic last_col_fire;

  assign row_last      = (row_cnt == ROW_CNT_W'(ROWS-1));
  assign COL_VALID     = (drain_state == DRAIN_FULL);
  assign col_fire      = COL_VALID & COL_READY;
  assign last_col_fire = col_fire & (col_idx == COL_IDX_W'(COLS-1));
  // A closing row may fire alongside the last column; the capture lands one edge later.
  assign ROW_READY     = !(row_last && (COL_VALID || capture_pend) && !last_col_fire);
  assign row_fire      = ROW_VALID & ROW_READY;
  assign BUF_WRITE_EN  = row_fire;

  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      row_cnt      <= '0;
      capture_pend <= 1'b0;
      drain_state  <= DRAIN_IDLE;
      col_idx      <= '0;
      block_done   <= 1'b0;
    end else begin
      block_done   <= last_col_fire;
      capture_pend <= row_fire & row_last;
      if (row_fire) begin
        row_cnt <= row_last ? '0 : row_cnt + ROW_CNT_W'(1);
      end
      if (capture_pend) begin
        drain_state <= DRAIN_FULL;
        col_idx     <= '0;
      end else if (last_col_fire) begin
        drain_state <= DRAIN_IDLE;
        col_idx     <= '0;
      end else if (col_fire) begin
        col_idx <= col_idx + COL_IDX_W'(1);
      end
    end
  end

  assign COL_IDX    = col_idx;
  assign BLOCK_DONE = block_done;

  tbuf_col_shadow u_shadow (
    .clk      (CLK),
    .rst_n    (RST_ASYNC_N),
    .capture  (capture_pend),
    .col_in_0 (COL_IN_0),
    .col_in_1 (COL_IN_1),
    .col_in_2 (COL_IN_2),
    .col_in_3 (COL_IN_3),
    .col_idx  (col_idx),
    .col_out  (COL_OUT)
  );

endmodule

// File: tb/tb_transposed_buffer_reader9x4.sv
// Directed bench for transposed_buffer_reader9x4 with a behavioural 9-deep shift buffer upstream.
// Expectations follow TBUF_READER_OLDEST_FIRST_EN when that macro is defined.
module tb_transposed_buffer_reader9x4;

  localparam int DW = 11;
  localparam int NR = 9;
  localparam int NC = 4;
  localparam int CW = NR * DW;

`ifdef TBUF_READER_OLDEST_FIRST_EN
  localparam logic [DW-1:0] C0_MSB = 11'd0;
  localparam logic [DW-1:0] C0_LSB = 11'd128;
`else
  localparam logic [DW-1:0] C0_MSB = 11'd128;
  localparam logic [DW-1:0] C0_LSB = 11'd0;
`endif

  logic          CLK = 1'b0;
  logic          RST_ASYNC_N;
  logic          ROW_VALID;
  logic          ROW_READY;
  logic          BUF_WRITE_EN;
  logic [CW-1:0] COL_IN_0, COL_IN_1, COL_IN_2, COL_IN_3;
  logic [CW-1:0] COL_OUT;
  logic [1:0]    COL_IDX;
  logic          COL_VALID;
  logic          COL_READY;
  logic          BLOCK_DONE;

  logic [DW-1:0] row_smp [NC];
  logic [CW-1:0] buf_col [NC];

  int n_checks = 0;
  int n_fail   = 0;

  transposed_buffer_reader9x4 dut (
    .CLK          (CLK),
    .RST_ASYNC_N  (RST_ASYNC_N),
    .ROW_VALID    (ROW_VALID),
    .ROW_READY    (ROW_READY),
    .BUF_WRITE_EN (BUF_WRITE_EN),
    .COL_IN_0     (COL_IN_0),
    .COL_IN_1     (COL_IN_1),
    .COL_IN_2     (COL_IN_2),
    .COL_IN_3     (COL_IN_3),
    .COL_OUT      (COL_OUT),
    .COL_IDX      (COL_IDX),
    .COL_VALID    (COL_VALID),
    .COL_READY    (COL_READY),
    .BLOCK_DONE   (BLOCK_DONE)
  );

  always #5 CLK = ~CLK;

  // Line buffer: each write shifts a new row in at the MSB end of every column.
  always @(posedge CLK) begin
    if (BUF_WRITE_EN) begin
      for (int c = 0; c < NC; c++) begin
        buf_col[c] <= {row_smp[c], buf_col[c][CW-1:DW]};
      end
    end
  end

  assign COL_IN_0 = buf_col[0];
  assign COL_IN_1 = buf_col[1];
  assign COL_IN_2 = buf_col[2];
  assign COL_IN_3 = buf_col[3];

  function automatic logic [DW-1:0] smp(input int blk, input int r, input int c);
    return DW'(blk * 100 + 16 * r + c);
  endfunction

  function automatic logic [CW-1:0] exp_col(input int blk, input int c);
    logic [CW-1:0] v;
    v = '0;
    for (int f = 0; f < NR; f++) begin
`ifdef TBUF_READER_OLDEST_FIRST_EN
      v[f*DW +: DW] = smp(blk, NR - 1 - f, c);
`else
      v[f*DW +: DW] = smp(blk, f, c);
`endif
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_row_ready"},  ROW_READY,  1);
    check({tag, "_col_valid"},  COL_VALID,  0);
    check({tag, "_col_out"},    COL_OUT,    0);
    check({tag, "_col_idx"},    COL_IDX,    0);
    check({tag, "_block_done"}, BLOCK_DONE, 0);
  endtask

  // Presents n rows of block blk back to back; ROW_VALID is left high afterwards.
  task automatic send_rows(input int blk, input int n);
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < NC; c++) row_smp[c] = smp(blk, r, c);
      ROW_VALID = 1'b1;
      #1;
      check("row_ready_fill", ROW_READY, 1);
      tick();
    end
  endtask

  // Expects column 0 of block blk on the outputs now, with COL_READY high throughout.
  task automatic drain_check(input int blk);
    for (int c = 0; c < NC; c++) begin
      check("drain_valid", COL_VALID, 1);
      check("drain_idx",   COL_IDX,   CW'(c));
      check("drain_col",   COL_OUT,   exp_col(blk, c));
      check("drain_no_done", BLOCK_DONE, 0);
      tick();
    end
    check("done_valid_low", COL_VALID,  0);
    check("done_pulse",     BLOCK_DONE, 1);
    tick();
    check("done_pulse_end", BLOCK_DONE, 0);
  endtask

  initial begin
    RST_ASYNC_N = 1'b0;
    ROW_VALID   = 1'b0;
    COL_READY   = 1'b0;
    for (int c = 0; c < NC; c++) row_smp[c] = '0;
    repeat (2) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    RST_ASYNC_N = 1'b1;
    tick();

    // Basic block, downstream always ready.
    COL_READY = 1'b1;
    send_rows(0, 9);
    ROW_VALID = 1'b0;
    check("lat_cycle1", COL_VALID, 0);
    tick();
    check("lat_cycle2", COL_VALID, 1);
    check("col0_msb", COL_OUT[CW-1 -: DW], C0_MSB);
    check("col0_lsb", COL_OUT[DW-1:0],     C0_LSB);
    drain_check(0);

    // Downstream stalls on column 2 for five cycles.
    send_rows(1, 9);
    ROW_VALID = 1'b0;
    tick();
    check("bp_idx0", COL_IDX, 0);
    tick();
    check("bp_idx1", COL_IDX, 1);
    tick();
    check("bp_idx2", COL_IDX, 2);
    COL_READY = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_hold_valid", COL_VALID, 1);
      check("bp_hold_idx",   COL_IDX,   2);
      check("bp_hold_col",   COL_OUT,   exp_col(1, 2));
    end
    COL_READY = 1'b1;
    tick();
    check("bp_rel_idx3", COL_IDX, 3);
    check("bp_rel_col3", COL_OUT, exp_col(1, 3));
    tick();
    check("bp_done_valid", COL_VALID,  0);
    check("bp_done_pulse", BLOCK_DONE, 1);
    tick();

    // Next block fills while the current one is held; 9th row waits for the last column.
    COL_READY = 1'b0;
    send_rows(2, 9);
    send_rows(3, 8);
    for (int c = 0; c < NC; c++) row_smp[c] = smp(3, 8, c);
    ROW_VALID = 1'b1;
    #1;
    check("ov_row_ready", ROW_READY,    0);
    check("ov_write_en",  BUF_WRITE_EN, 0);
    check("ov_valid",     COL_VALID,    1);
    check("ov_col0",      COL_OUT,      exp_col(2, 0));
    tick();
    check("ov_stall_ready", ROW_READY, 0);
    tick();
    check("ov_stall_ready2", ROW_READY, 0);
    COL_READY = 1'b1;
    #1;
    check("ov_rel_idx0_ready", ROW_READY, 0);
    tick();
    check("ov_idx1", COL_IDX,   1);
    check("ov_idx1_ready", ROW_READY, 0);
    tick();
    check("ov_idx2", COL_IDX,   2);
    tick();
    check("ov_idx3", COL_IDX,      3);
    check("ov_col3", COL_OUT,      exp_col(2, 3));
    check("ov_coincident_ready", ROW_READY,    1);
    check("ov_coincident_wen",   BUF_WRITE_EN, 1);
    tick();
    ROW_VALID = 1'b0;
    check("ov_after_valid", COL_VALID,  0);
    check("ov_after_done",  BLOCK_DONE, 1);
    tick();
    drain_check(3);

    // Reset in the middle of a block, then a clean block.
    send_rows(4, 5);
    ROW_VALID   = 1'b0;
    RST_ASYNC_N = 1'b0;
    #1;
    check_reset_outputs("midreset");
    tick();
    RST_ASYNC_N = 1'b1;
    tick();
    send_rows(5, 9);
    ROW_VALID = 1'b0;
    check("post_rst_lat1", COL_VALID, 0);
    tick();
    drain_check(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
